key_apb_ctrl: RTL
=================

KEY_APB_CTRL -- requirements
Module: key_apb_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, number of consecutive stable samples required to accept a key level change.
REQ-002 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-003 SHALL have parameter DATA_W, default 32, APB data width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first APB word address used.
REQ-005 SHALL have parameter TMO_CYCLES, default 255, maximum ACCESS-phase wait before abort.
REQ-006 bb_clk_in  in  1  sole clock; all state updates on its rising edge.
REQ-007 key4  in  1  reset, asynchronous, active-low.
REQ-008 key0  in  1  raw push-button, active-high, asynchronous to bb_clk_in.
REQ-009 paddr  out  ADDR_W  APB address.
REQ-010 psel  out  1  APB select.
REQ-011 penable  out  1  APB enable.
REQ-012 pwrite  out  1  APB direction, 1 = write.
REQ-013 pwdata  out  DATA_W  APB write data.
REQ-014 prdata  in  DATA_W  APB read data.
REQ-015 pready  in  1  APB ready.
REQ-016 pslverr  in  1  APB slave error.
REQ-017 busy  out  1  high whenever FSM is not IDLE.
REQ-018 match  out  1  result of the last completed readback compare.
REQ-019 err  out  1  sticky error flag.
REQ-020 wr_cnt  out  8  count of completed writes.

Function
REQ-021 key0 SHALL pass through a two-flop synchronizer before any other use.
REQ-022 Debounce: while synchronized key0 differs from the accepted level, a counter SHALL increment each cycle; on reaching DB_CYCLES, the accepted level SHALL update and the counter SHALL clear; any cycle of agreement SHALL clear the counter.
REQ-023 A press event SHALL be a one-cycle pulse on an accepted-level 0->1 transition; releases SHALL generate no event.
REQ-024 FSM states SHALL be IDLE, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS.
REQ-025 IDLE->W_SETUP on press event; if k is the first edge sampling key0 high and key0 stays high, psel SHALL first be high after edge k+DB_CYCLES+2.
REQ-026 Press events while busy=1 SHALL be dropped, with no queuing.
REQ-027 W_SETUP: psel=1, penable=0, pwrite=1; always exactly one cycle, then W_ACCESS.
REQ-028 W_ACCESS: psel=1, penable=1; all APB outputs SHALL stay constant until the cycle pready=1; that cycle completes the write, and the next state is R_SETUP.
REQ-029 R_SETUP and R_ACCESS SHALL mirror REQ-027/028 with pwrite=0 and the same paddr; read completion returns to IDLE.
REQ-030 paddr SHALL be BASE_ADDR + 4*wr_cnt[1:0], truncated to ADDR_W, and SHALL wrap over four words.
REQ-031 pwdata SHALL be {DATA_W-8 zero bits, wr_cnt+1 mod 256}.
REQ-032 wr_cnt SHALL increment, mod 256, on the edge ending write completion, wrapping 255->0.
REQ-033 On read completion, match SHALL load (prdata == the transaction's written data).
REQ-034 err SHALL set on a completion with pslverr=1, or on a read mismatch; it clears only on reset.
REQ-035 A write pslverr SHALL still proceed to readback.
REQ-036 Each ACCESS cycle with pready=0 SHALL increment a wait counter, cleared on entering any SETUP state.
REQ-037 When the wait counter reaches TMO_CYCLES, the FSM SHALL abort to IDLE, set err, and leave match unchanged; a write timeout SHALL NOT increment wr_cnt.
REQ-038 In IDLE, psel=0, penable=0, and paddr/pwdata/pwrite SHALL hold their last values.
REQ-039 All outputs SHALL be registered.

Reset
REQ-040 While key4=0, FSM=IDLE; psel, penable, pwrite, busy, match, err = 0; paddr, pwdata, wr_cnt = 0; synchronizer, accepted level and counters = 0.
REQ-041 Reset asserted mid-transfer SHALL immediately drop psel/penable; the first transfer after reset SHALL use wr_cnt=0.

Verification
REQ-042 key0 high 5 cycles, pready=1, memory model echoes -> one write to addr 0x00 with data 0x1, then a read of 0x00; match=1, wr_cnt=1, err=0, psel active 4 cycles.
REQ-043 key0 glitches of 1-3 cycles (DB_CYCLES=4) -> no APB activity, busy stays 0.
REQ-044 Five clean presses -> addresses 0x00, 0x04, 0x08, 0x0C, 0x00; data 0x1..0x5; wr_cnt=5.
REQ-045 Slave corrupts read data -> match=0, err=1; a later good transfer gives match=1 while err stays 1.
REQ-046 pready held 0 in W_ACCESS -> abort after TMO_CYCLES waits; err=1, wr_cnt unchanged, busy=0; a second press during busy is ignored.
REQ-047 key4 pulsed low during R_ACCESS -> all outputs 0 asynchronously; next press writes address 0x00 with data 0x1.

Source files
------------

// File: rtl/key_apb_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_apb_ctrl_if
// APB bus bundle shared by the push-button APB controller and its slave.
//   paddr   [ADDR_W] : word address            (master -> slave)
//   psel             : select                  (master -> slave)
//   penable          : access phase            (master -> slave)
//   pwrite           : 1 = write, 0 = read     (master -> slave)
//   pwdata  [DATA_W] : write data              (master -> slave)
//   prdata  [DATA_W] : read data               (slave  -> master)
//   pready           : transfer ready          (slave  -> master)
//   pslverr          : slave error             (slave  -> master)
// ---------------------------------------------------------------------------
interface key_apb_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/key_apb_ctrl.sv
// ---------------------------------------------------------------------------
// key_apb_ctrl
// A debounced push-button press launches one APB write followed by a
// readback of the same word; the readback is compared against the data
// written. Four words starting at BASE_ADDR are used round-robin.
//   bb_clk_in : clock, rising edge
//   key4      : asynchronous active-low reset
//   key0      : raw push-button, active-high, asynchronous
//   apb       : APB master port (key_apb_ctrl_if.master)
//   busy      : transfer sequence in progress
//   match     : result of the last completed readback compare
//   err       : sticky error (slave error, read mismatch or timeout)
//   wr_cnt    : number of completed writes, mod 256
// ---------------------------------------------------------------------------
module key_apb_ctrl #(
    parameter int DB_CYCLES  = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int BASE_ADDR  = 0,
    parameter int TMO_CYCLES = 255
) (
    input  logic                  bb_clk_in,
    input  logic                  key4,
    input  logic                  key0,
    key_apb_ctrl_if.master        apb,
    output logic                  busy,
    output logic                  match,
    output logic                  err,
    output logic [7:0]            wr_cnt
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int TW   = $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_ACCESS,
        R_SETUP,
        R_ACCESS
    } state_t;

    logic              r_sync1, r_sync2;
    logic              r_key_lvl;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_press;

    state_t            r_state, w_state_nxt;
    logic              w_wr_done, w_rd_done, w_tmo, w_wait_hit;
    logic [TW-1:0]     r_wait;

    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_psel, r_penable, r_pwrite;
    logic              r_busy, r_match, r_err;
    logic [7:0]        r_wr_cnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Synchronizer and debounce; r_press pulses only on an accepted 0->1.
    always_ff @(posedge bb_clk_in or negedge key4) begin
        if (!key4) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_key_lvl <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= key0;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_key_lvl) begin
                // The DB_CYCLES-th differing sample is the one that flips the level.
                if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    r_key_lvl <= r_sync2;
                    r_db_cnt  <= '0;
                    r_press   <= r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge bb_clk_in or negedge key4) begin
        if (!key4) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_done   = 1'b0;
        w_rd_done   = 1'b0;
        w_tmo       = 1'b0;
        w_wait_hit  = (r_wait == TW'(TMO_CYCLES - 1));
        case (r_state)
            IDLE:     if (r_press) w_state_nxt = W_SETUP;
            W_SETUP:  w_state_nxt = W_ACCESS;
            W_ACCESS: begin
                if (apb.pready) begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = R_SETUP;
                end else if (w_wait_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            R_SETUP:  w_state_nxt = R_ACCESS;
            R_ACCESS: begin
                if (apb.pready) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wait_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    assign w_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'({r_wr_cnt[1:0], 2'b00});
    assign w_wdata = DATA_W'(r_wr_cnt + 8'd1);

    // Bus and status registers are loaded from the next-state decode so
    // every output changes on the same edge as the state.
    always_ff @(posedge bb_clk_in or negedge key4) begin
        if (!key4) begin
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_busy    <= 1'b0;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
            r_wr_cnt  <= '0;
            r_wait    <= '0;
        end else begin
            r_psel    <= (w_state_nxt != IDLE);
            r_penable <= (w_state_nxt == W_ACCESS) || (w_state_nxt == R_ACCESS);
            r_busy    <= (w_state_nxt != IDLE);

            if (r_state == IDLE && w_state_nxt == W_SETUP) begin
                r_paddr  <= w_addr;
                r_pwdata <= w_wdata;
                r_pwrite <= 1'b1;
            end
            if (w_state_nxt == R_SETUP) r_pwrite <= 1'b0;

            if (w_state_nxt == W_SETUP || w_state_nxt == R_SETUP)
                r_wait <= '0;
            else if ((r_state == W_ACCESS || r_state == R_ACCESS) && !apb.pready)
                r_wait <= r_wait + TW'(1);

            if (w_wr_done) r_wr_cnt <= r_wr_cnt + 8'd1;
            if (w_rd_done) r_match  <= (apb.prdata == r_pwdata);

            if ((w_wr_done || w_rd_done) && apb.pslverr) r_err <= 1'b1;
            if (w_rd_done && (apb.prdata != r_pwdata))   r_err <= 1'b1;
            if (w_tmo)                                   r_err <= 1'b1;
        end
    end

    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;
    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwrite  = r_pwrite;
    assign busy        = r_busy;
    assign match       = r_match;
    assign err         = r_err;
    assign wr_cnt      = r_wr_cnt;
endmodule
